// File: rtl/can_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : can_transmitter
//  Description : CAN 2.0A/2.0B frame serializer. Produces the unstuffed frame
//                bit stream, the CRC-15, arbitration-loss detection and
//                ACK-slot checking. Bit stuffing itself is done externally.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst          clock / asynchronous active-high reset
//    tx_point          one-cycle strobe at each bit boundary
//    sample_point      one-cycle strobe at the bus sample instant
//    rx_bit            bus level at sample_point (0 = dominant)
//    insert_stuff_bit  external stuffer owns the current bit time
//    tx_start          frame request (accepted only when idle)
//    tx_id_std/ext, tx_ide, tx_rtr, tx_dlc, tx_data   frame content
//    tx_bit            unstuffed frame bit (1 = recessive)
//    stuff_enable      high from SOF through the last CRC bit
//    tx_busy, tx_done, arb_lost, ack_error   status
// ============================================================================
module can_transmitter (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_point,
    input  logic        sample_point,
    input  logic        rx_bit,
    input  logic        insert_stuff_bit,
    input  logic        tx_start,
    input  logic [10:0] tx_id_std,
    input  logic [17:0] tx_id_ext,
    input  logic        tx_ide,
    input  logic        tx_rtr,
    input  logic [3:0]  tx_dlc,
    input  logic [63:0] tx_data,
    output logic        tx_bit,
    output logic        stuff_enable,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        arb_lost,
    output logic        ack_error
);

    localparam logic [14:0] C_CRC_POLY = 15'h4599;

    typedef enum logic [4:0] {
        IDLE        = 5'd0,  WAIT_SOF    = 5'd1,  SOF   = 5'd2,  ID_STD = 5'd3,
        RTR_1       = 5'd4,  IDE         = 5'd5,  ID_EXT = 5'd6, RTR_2  = 5'd7,
        R_1         = 5'd8,  R_0         = 5'd9,  DLC   = 5'd10, DATA   = 5'd11,
        CRC         = 5'd12, CRC_DELIMIT = 5'd13, ACK   = 5'd14, ACK_DELIMIT = 5'd15,
        EOF         = 5'd16, IFS         = 5'd17
    } state_t;

    state_t      state_q,  state_d;
    logic [5:0]  cnt_q,    cnt_d;
    logic [10:0] id_std_q, id_std_d;
    logic [17:0] id_ext_q, id_ext_d;
    logic        ide_q,    ide_d;
    logic        rtr_q,    rtr_d;
    logic [3:0]  dlc_q,    dlc_d;
    logic [63:0] data_q,   data_d;
    logic [14:0] crc_q,    crc_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;
    logic        arb_q,    arb_d;
    logic        ack_err_q, ack_err_d;

    // Bit-select indices, sized to their target vectors (MSB first).
    logic [3:0]  w_idx_std;
    logic [4:0]  w_idx_ext;
    logic [1:0]  w_idx_dlc;
    logic [5:0]  w_idx_data;
    logic [3:0]  w_idx_crc;
    logic [3:0]  w_nbytes;
    logic [6:0]  w_data_bits;
    logic        w_adv;
    logic        w_arb_field;
    logic        w_crc_field;
    logic        w_crc_nxt;

    assign w_idx_std   = 4'd10 - cnt_q[3:0];
    assign w_idx_ext   = 5'd17 - cnt_q[4:0];
    assign w_idx_dlc   = 2'd3  - cnt_q[1:0];
    assign w_idx_data  = 6'd63 - cnt_q;
    assign w_idx_crc   = 4'd14 - cnt_q[3:0];

    // DLC codes 9..15 still carry only 8 data bytes.
    assign w_nbytes    = dlc_q[3] ? 4'd8 : dlc_q;
    assign w_data_bits = {w_nbytes, 3'b000};

    // Stuff bit times do not belong to the frame: nothing moves during them.
    assign w_adv       = tx_point & ~insert_stuff_bit;

    // IDE is only an arbitration bit in extended frames (it follows SRR there).
    assign w_arb_field = (state_q inside {ID_STD, RTR_1, ID_EXT, RTR_2}) ||
                         (state_q == IDE && ide_q);
    assign w_crc_field = state_q inside {SOF, ID_STD, RTR_1, IDE, ID_EXT, RTR_2,
                                         R_1, R_0, DLC, DATA};
    assign w_crc_nxt   = tx_bit ^ crc_q[14];

    assign stuff_enable = state_q inside {SOF, ID_STD, RTR_1, IDE, ID_EXT, RTR_2,
                                          R_1, R_0, DLC, DATA, CRC};
    assign tx_busy      = busy_q;
    assign tx_done      = done_q;
    assign arb_lost     = arb_q;
    assign ack_error    = ack_err_q;

    // Frame bit is a pure function of state and bit counter.
    always_comb begin
        tx_bit = 1'b1;
        case (state_q)
            SOF:     tx_bit = 1'b0;
            ID_STD:  tx_bit = id_std_q[w_idx_std];
            RTR_1:   tx_bit = ide_q ? 1'b1 : rtr_q;   // SRR in extended frames
            IDE:     tx_bit = ide_q;
            ID_EXT:  tx_bit = id_ext_q[w_idx_ext];
            RTR_2:   tx_bit = rtr_q;
            R_1:     tx_bit = 1'b0;
            R_0:     tx_bit = 1'b0;
            DLC:     tx_bit = dlc_q[w_idx_dlc];
            DATA:    tx_bit = data_q[w_idx_data];
            CRC:     tx_bit = crc_q[w_idx_crc];
            default: tx_bit = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        id_std_d  = id_std_q;
        id_ext_d  = id_ext_q;
        ide_d     = ide_q;
        rtr_d     = rtr_q;
        dlc_d     = dlc_q;
        data_d    = data_q;
        crc_d     = crc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        arb_d     = 1'b0;
        ack_err_d = ack_err_q;

        if (state_q == IDLE) begin
            if (tx_start) begin
                id_std_d  = tx_id_std;
                id_ext_d  = tx_id_ext;
                ide_d     = tx_ide;
                rtr_d     = tx_rtr;
                dlc_d     = tx_dlc;
                data_d    = tx_data;
                crc_d     = '0;
                cnt_d     = '0;
                busy_d    = 1'b1;
                ack_err_d = 1'b0;
                state_d   = WAIT_SOF;
            end
        end else if (sample_point && w_arb_field && tx_bit && !rx_bit) begin
            // Sent recessive, saw dominant: another node wins arbitration.
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            arb_d   = 1'b1;
        end else begin
            if (sample_point && state_q == ACK && rx_bit) begin
                ack_err_d = 1'b1;
            end
            if (w_adv) begin
                if (w_crc_field) begin
                    crc_d = {crc_q[13:0], 1'b0} ^ (w_crc_nxt ? C_CRC_POLY : 15'h0);
                end
                cnt_d = cnt_q + 6'd1;
                case (state_q)
                    WAIT_SOF:    state_d = SOF;
                    SOF:         state_d = ID_STD;
                    ID_STD:      if (cnt_q == 6'd10) state_d = RTR_1;
                    RTR_1:       state_d = IDE;
                    IDE:         state_d = ide_q ? ID_EXT : R_0;
                    ID_EXT:      if (cnt_q == 6'd17) state_d = RTR_2;
                    RTR_2:       state_d = R_1;
                    R_1:         state_d = R_0;
                    R_0:         state_d = DLC;
                    DLC:         if (cnt_q == 6'd3)
                                     state_d = (rtr_q || dlc_q == 4'd0) ? CRC : DATA;
                    DATA:        if ({1'b0, cnt_q} == w_data_bits - 7'd1) state_d = CRC;
                    CRC:         if (cnt_q == 6'd14) state_d = CRC_DELIMIT;
                    CRC_DELIMIT: state_d = ACK;
                    ACK:         state_d = ACK_DELIMIT;
                    ACK_DELIMIT: state_d = EOF;
                    EOF:         if (cnt_q == 6'd6) state_d = IFS;
                    IFS: begin
                        if (cnt_q == 6'd2) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                    default:     state_d = IDLE;
                endcase
                // Every field starts counting its bits from zero.
                if (state_d != state_q) begin
                    cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            id_std_q  <= '0;
            id_ext_q  <= '0;
            ide_q     <= 1'b0;
            rtr_q     <= 1'b0;
            dlc_q     <= '0;
            data_q    <= '0;
            crc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            arb_q     <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            id_std_q  <= id_std_d;
            id_ext_q  <= id_ext_d;
            ide_q     <= ide_d;
            rtr_q     <= rtr_d;
            dlc_q     <= dlc_d;
            data_q    <= data_d;
            crc_q     <= crc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            arb_q     <= arb_d;
            ack_err_q <= ack_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_can_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_can_transmitter
//  Description : Directed self-checking bench for can_transmitter. A frame
//                model builds the expected unstuffed bit list (including the
//                CRC-15); frames are clocked out with 4-cycle bit times.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_can_transmitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_point, sample_point, rx_bit, insert_stuff_bit, tx_start;
    logic [10:0] tx_id_std;
    logic [17:0] tx_id_ext;
    logic        tx_ide, tx_rtr;
    logic [3:0]  tx_dlc;
    logic [63:0] tx_data;
    logic        tx_bit, stuff_enable, tx_busy, tx_done, arb_lost, ack_error;

    int n_vec = 0;
    int n_err = 0;
    int stuff_period = 0;
    int tp_cnt = 0;
    int se_last = 0;
    int ack_idx = 0;
    logic exp_q[$];
    logic obs_q[$];

    always #5 clk = ~clk;

    can_transmitter dut (
        .clk              (clk),
        .rst              (rst),
        .tx_point         (tx_point),
        .sample_point     (sample_point),
        .rx_bit           (rx_bit),
        .insert_stuff_bit (insert_stuff_bit),
        .tx_start         (tx_start),
        .tx_id_std        (tx_id_std),
        .tx_id_ext        (tx_id_ext),
        .tx_ide           (tx_ide),
        .tx_rtr           (tx_rtr),
        .tx_dlc           (tx_dlc),
        .tx_data          (tx_data),
        .tx_bit           (tx_bit),
        .stuff_enable     (stuff_enable),
        .tx_busy          (tx_busy),
        .tx_done          (tx_done),
        .arb_lost         (arb_lost),
        .ack_error        (ack_error)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive the request fields and build the expected bit list of the frame.
    task automatic set_req(input logic [10:0] ids, input logic [17:0] idx, input logic ide,
                           input logic rtr, input logic [3:0] dlc, input logic [63:0] data);
        logic [10:0] s;
        logic [17:0] x;
        logic [3:0]  d;
        logic [63:0] p;
        logic [14:0] crc;
        logic        nxt;
        int          n;
        tx_id_std = ids; tx_id_ext = idx; tx_ide = ide; tx_rtr = rtr;
        tx_dlc = dlc; tx_data = data;
        exp_q.delete();
        exp_q.push_back(1'b0);
        s = ids;
        repeat (11) begin exp_q.push_back(s[10]); s = s << 1; end
        if (ide) begin
            exp_q.push_back(1'b1);            // SRR
            exp_q.push_back(1'b1);            // IDE
            x = idx;
            repeat (18) begin exp_q.push_back(x[17]); x = x << 1; end
            exp_q.push_back(rtr);
            exp_q.push_back(1'b0);            // r1
            exp_q.push_back(1'b0);            // r0
        end else begin
            exp_q.push_back(rtr);
            exp_q.push_back(1'b0);            // IDE
            exp_q.push_back(1'b0);            // r0
        end
        d = dlc;
        repeat (4) begin exp_q.push_back(d[3]); d = d << 1; end
        n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        p = data;
        repeat (8 * n) begin exp_q.push_back(p[63]); p = p << 1; end
        crc = 15'h0;
        foreach (exp_q[k]) begin
            nxt = exp_q[k] ^ crc[14];
            crc = {crc[13:0], 1'b0} ^ (nxt ? 15'h4599 : 15'h0);
        end
        repeat (15) begin exp_q.push_back(crc[14]); crc = crc << 1; end
        se_last = exp_q.size() - 1;
        exp_q.push_back(1'b1);                // CRC delimiter
        ack_idx = exp_q.size();
        repeat (12) exp_q.push_back(1'b1);    // ACK, ACK delim, EOF, IFS
    endtask

    task automatic tp_pulse(output logic stuffed);
        @(negedge clk);
        tp_cnt++;
        stuffed = (stuff_period > 0) && (tp_cnt % stuff_period == 0);
        tx_point = 1'b1;
        insert_stuff_bit = stuffed;
        @(negedge clk);
        tx_point = 1'b0;
        insert_stuff_bit = 1'b0;
    endtask

    task automatic sample(input logic rx);
        @(negedge clk);
        sample_point = 1'b1;
        rx_bit = rx;
        @(negedge clk);
        sample_point = 1'b0;
        rx_bit = 1'b1;
    endtask

    // Clock one frame out. arb_idx / rst_idx < 0 disable the loss / reset
    // injection; poke_start fires an extra tx_start during bit 5.
    task automatic run_frame(input string nm, input int len, input logic ack_rx,
                             input int arb_idx, input int rst_idx, input logic poke_start,
                             input logic exp_ack);
        logic st, prev, prev_rx, rx, b;
        @(negedge clk);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check_val({nm, "_busy_start"}, 64'(tx_busy), 64'd1);
        check_val({nm, "_ackerr_start"}, 64'(ack_error), 64'd0);
        obs_q.delete();
        prev = 1'b1;
        prev_rx = 1'b1;
        for (int i = 0; i < len; i++) begin
            do begin
                tp_pulse(st);
                if (st) begin
                    check_val($sformatf("%s_held%0d", nm, i), 64'(tx_bit), 64'(prev));
                    sample(prev_rx);
                end
            end while (st);
            b = (i < exp_q.size()) ? exp_q[i] : 1'b1;
            obs_q.push_back(tx_bit);
            check_val($sformatf("%s_bit%0d", nm, i), 64'(tx_bit), 64'(b));
            check_val($sformatf("%s_se%0d", nm, i), 64'(stuff_enable), 64'(i <= se_last));
            check_val($sformatf("%s_stat%0d", nm, i), 64'({tx_busy, tx_done, arb_lost}), 64'(3'b100));
            if (i == rst_idx) begin
                #2 rst = 1'b1;
                #1;
                check_val({nm, "_rst_txbit"}, 64'(tx_bit), 64'd1);
                check_val({nm, "_rst_stat"}, 64'({stuff_enable, tx_busy, tx_done, arb_lost, ack_error}), 64'd0);
                @(negedge clk);
                rst = 1'b0;
                check_val({nm, "_post_rst"}, 64'({tx_bit, stuff_enable, tx_busy}), 64'(3'b100));
                return;
            end
            if (poke_start && i == 5) begin
                tx_start = 1'b1;
                tx_id_std = ~tx_id_std;
                tx_data = ~tx_data;
                tx_dlc = 4'd8;
                @(negedge clk);
                tx_start = 1'b0;
            end
            rx = (i == ack_idx) ? ack_rx : b;
            if (i == arb_idx) begin
                sample(1'b0);
                check_val({nm, "_arb_pulse"}, 64'({arb_lost, tx_busy, tx_bit}), 64'(3'b101));
                @(negedge clk);
                check_val({nm, "_arb_after"}, 64'({arb_lost, tx_busy, tx_bit}), 64'(3'b001));
                return;
            end
            sample(rx);
            prev = b;
            prev_rx = rx;
        end
        do begin
            tp_pulse(st);
            if (st) begin
                check_val({nm, "_held_last"}, 64'(tx_bit), 64'(prev));
                sample(prev_rx);
            end
        end while (st);
        check_val({nm, "_done"}, 64'({tx_busy, tx_done}), 64'(2'b01));
        check_val({nm, "_ackerr"}, 64'(ack_error), 64'(exp_ack));
        @(negedge clk);
        check_val({nm, "_done_pulse"}, 64'(tx_done), 64'd0);
    endtask

    initial begin
        logic [26:0] hdr;
        logic        st;
        rst = 1'b1;
        tx_point = 1'b0; sample_point = 1'b0; rx_bit = 1'b1;
        insert_stuff_bit = 1'b0; tx_start = 1'b0;
        tx_id_std = '0; tx_id_ext = '0; tx_ide = 1'b0; tx_rtr = 1'b0;
        tx_dlc = '0; tx_data = '0;
        repeat (3) @(negedge clk);
        check_val("reset_txbit", 64'(tx_bit), 64'd1);
        check_val("reset_status", 64'({stuff_enable, tx_busy, tx_done, arb_lost, ack_error}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_status", 64'({tx_bit, stuff_enable, tx_busy}), 64'(3'b100));

        // Standard data frame, id 0x123, one byte 0xA5; extra tx_start mid-frame.
        set_req(11'h123, 18'h0, 1'b0, 1'b0, 4'd1, 64'hA500_0000_0000_0000);
        run_frame("std", 55, 1'b0, -1, -1, 1'b1, 1'b0);
        hdr = '0;
        for (int k = 0; k < 27; k++) hdr = {hdr[25:0], obs_q[k]};
        check_val("std_header", 64'(hdr), 64'(27'b0_00100100011_000_0001_10100101));

        // Extended remote frame: 1+11+2+18+3+4+15+3+7+3 = 67 bit times.
        set_req(11'h7FF, 18'h3FFFF, 1'b1, 1'b1, 4'd4, 64'h0123_4567_89AB_CDEF);
        run_frame("ext", 67, 1'b0, -1, -1, 1'b0, 1'b0);

        // Same standard frame with a stuff bit time on every 5th tx_point.
        stuff_period = 5;
        tp_cnt = 0;
        set_req(11'h123, 18'h0, 1'b0, 1'b0, 4'd1, 64'hA500_0000_0000_0000);
        run_frame("stf", 55, 1'b0, -1, -1, 1'b0, 1'b0);
        stuff_period = 0;

        // Arbitration loss at ID_STD bit 2 (frame bit 3, recessive for 0x555).
        set_req(11'h555, 18'h0, 1'b0, 1'b0, 4'd2, 64'hDEAD_BEEF_0000_0000);
        run_frame("arb", 63, 1'b0, 3, -1, 1'b0, 1'b0);

        // DLC 0, no acknowledge: 1+11+3+4+15+3+7+3 = 47 bit times.
        set_req(11'h0F0, 18'h0, 1'b0, 1'b0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_frame("d0", 47, 1'b1, -1, -1, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        check_val("ackerr_sticky", 64'(ack_error), 64'd1);

        // Reset in the middle of DATA (frame bit 22), then nothing restarts.
        set_req(11'h2AA, 18'h0, 1'b0, 1'b0, 4'd8, 64'h1122_3344_5566_7788);
        run_frame("rst", 111, 1'b0, -1, 22, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tp_pulse(st);
            check_val($sformatf("rst_idle%0d", k), 64'({tx_bit, stuff_enable, tx_busy}), 64'(3'b100));
            sample(1'b1);
        end

        // DLC 9 is sent as-is with 8 data bytes: 1+11+3+4+64+15+3+7+3 = 111.
        set_req(11'h7A5, 18'h0, 1'b0, 1'b0, 4'd9, 64'hF0E1_D2C3_B4A5_9687);
        run_frame("d9", 111, 1'b0, -1, -1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
